// File: rtl/if_stage_pkg.sv
// Shared ISA definitions for the 16-bit pipelined processor: opcode
// encodings and the bubble word, common to the fetch stage and control decoder.
package if_stage_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 8;
  localparam int OP_WIDTH   = 4;

  localparam logic [OP_WIDTH-1:0] OP_LW    = 4'b0000;
  localparam logic [OP_WIDTH-1:0] OP_SW    = 4'b0001;
  localparam logic [OP_WIDTH-1:0] OP_ADD   = 4'b0010;
  localparam logic [OP_WIDTH-1:0] OP_MOV   = 4'b0011;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 4'b0100;
  localparam logic [OP_WIDTH-1:0] OP_JMPZ  = 4'b0101;
  localparam logic [OP_WIDTH-1:0] OP_JUMP  = 4'b0110;
  localparam logic [OP_WIDTH-1:0] OP_STOP  = 4'b0111;
  localparam logic [OP_WIDTH-1:0] OP_ADDF  = 4'b1000;
  localparam logic [OP_WIDTH-1:0] OP_MULTF = 4'b1001;
  localparam logic [OP_WIDTH-1:0] OP_SLT   = 4'b1010;
  localparam logic [OP_WIDTH-1:0] OP_NOP   = 4'b1111;

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 16'hF000;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_stage_pc_unit.sv
// Program counter register with next-PC selection: redirect target, hold, or
// increment modulo 2^ADDR_WIDTH.
module pc_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic                  hold,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  // Redirect beats hold; the increment wraps naturally at the register width.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!hold) begin
      pc <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, stall/redirect
// handling and a RUN/HALT controller that stops fetch after STOP.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    OP_WIDTH   = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 16'hF000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [OP_WIDTH-1:0]   opcode_o,
  output logic [ADDR_WIDTH-1:0] pc_plus1_o,
  output logic                  valid_o,
  output logic                  halted_o,
  output logic [15:0]           fetch_cnt_o
);

  fetch_state_t          state, state_next;
  logic                  pc_redirect, pc_hold, ifid_load, ifid_flush;
  logic                  stop_seen;
  logic [ADDR_WIDTH-1:0] pc;

  pc_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc (
    .clk         (clk),
    .rst         (rst),
    .redirect    (pc_redirect),
    .hold        (pc_hold),
    .redirect_pc (redirect_pc_i),
    .pc          (pc)
  );

  assign imem_addr_o = pc;
  assign opcode_o    = instr_o[DATA_WIDTH-1 -: OP_WIDTH];
  assign stop_seen   = valid_o && (opcode_o == OP_WIDTH'(OP_STOP));
  assign halted_o    = (state == FETCH_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Per-cycle priority in RUN: redirect, then STOP (unless stalled), then stall, then fetch.
  always_comb begin
    state_next  = state;
    pc_redirect = 1'b0;
    pc_hold     = 1'b1;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    case (state)
      FETCH_RUN: begin
        if (redirect_i) begin
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
        end else if (stop_seen && !stall_i) begin
          state_next = FETCH_HALT;
          ifid_flush = 1'b1;
        end else if (!stall_i) begin
          pc_hold   = 1'b0;
          ifid_load = 1'b1;
        end
      end
      FETCH_HALT: begin
        ifid_flush = 1'b1;
      end
      default: begin
        state_next = FETCH_RUN;
      end
    endcase
  end

  // IF/ID register; a flush inserts a bubble but keeps the branch base and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_o     <= NOP_INSTR;
      pc_plus1_o  <= '0;
      valid_o     <= 1'b0;
      fetch_cnt_o <= '0;
    end else if (ifid_flush) begin
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (ifid_load) begin
      instr_o    <= imem_data_i;
      pc_plus1_o <= pc + ADDR_WIDTH'(1);
      valid_o    <= 1'b1;
      if (fetch_cnt_o != 16'hFFFF) begin
        fetch_cnt_o <= fetch_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  pc_plus1;
  logic        valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [15:0] imem [256];

  int checks = 0;
  int errors = 0;

  int          m_pc;
  logic [15:0] m_instr;
  int          m_pp1;
  logic        m_valid;
  logic        m_halted;
  int          m_cnt;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .opcode_o      (opcode),
    .pc_plus1_o    (pc_plus1),
    .valid_o       (valid),
    .halted_o      (halted),
    .fetch_cnt_o   (fetch_cnt)
  );

  function automatic logic [53:0] dut_vec();
    return {imem_addr, instr, opcode, pc_plus1, valid, halted, fetch_cnt};
  endfunction

  function automatic logic [53:0] model_vec();
    return {8'(m_pc), m_instr, m_instr[15:12], 8'(m_pp1), m_valid, m_halted, 16'(m_cnt)};
  endfunction

  // Model of one clock edge, taken straight from the fetch rules.
  task automatic model_edge(input logic r, input logic s, input logic d, input int t);
    if (r) begin
      m_pc = 0; m_instr = 16'hF000; m_pp1 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
    end else if (m_halted) begin
      m_instr = 16'hF000; m_valid = 0;
    end else if (d) begin
      m_pc = t; m_instr = 16'hF000; m_valid = 0;
    end else if (m_valid && m_instr[15:12] == 4'd7 && !s) begin
      m_halted = 1; m_instr = 16'hF000; m_valid = 0;
    end else if (!s) begin
      m_instr = imem[m_pc];
      m_pp1   = (m_pc + 1) % 256;
      m_pc    = (m_pc + 1) % 256;
      m_valid = 1;
      m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic d, input logic [7:0] t);
    rst = r; stall = s; redirect = d; redirect_pc = t;
    @(posedge clk);
    model_edge(r, s, d, int'(t));
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) imem[i] = 16'h2000 + 16'(i);
    tick(1, 0, 0, 8'h00);
    tick(1, 1, 1, 8'h33);
    checks++;
    if (dut_vec() !== {8'h00, 16'hF000, 4'hF, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL reset: got %h want %h", dut_vec(), {8'h00, 16'hF000, 4'hF, 8'h00, 1'b0, 1'b0, 16'h0000});
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 8'h00);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL seq[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (imem_addr !== 8'd8 || instr !== 16'h2007 || fetch_cnt !== 16'd8 || !valid) begin
      errors++;
      $display("[TB] FAIL seq_end: addr=%h instr=%h cnt=%0d valid=%b want 08/2007/8/1", imem_addr, instr, fetch_cnt, valid);
    end
  endtask

  task automatic test_stall();
    logic [7:0] held_pc;
    imem[m_pc] = 16'h0123;
    tick(0, 0, 0, 8'h00);
    held_pc = imem_addr;
    checks++;
    if (instr !== 16'h0123 || opcode !== 4'h0) begin
      errors++;
      $display("[TB] FAIL stall_setup: instr=%h opcode=%h want 0123/0", instr, opcode);
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 0, 8'h00);
      checks++;
      if (dut_vec() !== model_vec() || instr !== 16'h0123 || imem_addr !== held_pc) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    tick(0, 0, 0, 8'h00);
    checks++;
    if (dut_vec() !== model_vec() || instr !== imem[held_pc]) begin
      errors++;
      $display("[TB] FAIL stall_resume: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_redirect();
    tick(0, 1, 1, 8'h40);
    checks++;
    if (imem_addr !== 8'h40 || instr !== 16'hF000 || valid !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL redirect: got %h want %h", dut_vec(), model_vec());
    end
    tick(0, 0, 0, 8'h00);
    checks++;
    if (instr !== 16'h2040 || valid !== 1'b1 || pc_plus1 !== 8'h41) begin
      errors++;
      $display("[TB] FAIL redirect_fetch: instr=%h valid=%b pp1=%h want 2040/1/41", instr, valid, pc_plus1);
    end
  endtask

  task automatic test_stop_vs_redirect();
    imem[m_pc] = 16'h7000;
    tick(0, 0, 0, 8'h00);
    tick(0, 0, 1, 8'h80);
    checks++;
    if (halted !== 1'b0 || imem_addr !== 8'h80 || valid !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL stop_redirect: got %h want %h", dut_vec(), model_vec());
    end
    imem[int'(imem_addr)] = 16'h2000 + 16'(imem_addr);
  endtask

  task automatic test_stop();
    logic [7:0] frozen_pc;
    imem[m_pc] = 16'h7000;
    tick(0, 0, 0, 8'h00);
    tick(0, 1, 0, 8'h00);
    checks++;
    if (halted !== 1'b0 || instr !== 16'h7000 || valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stop_stalled: halted=%b instr=%h valid=%b want 0/7000/1", halted, instr, valid);
    end
    frozen_pc = imem_addr;
    tick(0, 0, 0, 8'h00);
    checks++;
    if (halted !== 1'b1 || valid !== 1'b0 || instr !== 16'hF000 || imem_addr !== frozen_pc) begin
      errors++;
      $display("[TB] FAIL stop_halt: got %h want %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 1'($urandom), 1'($urandom), 8'($urandom));
      checks++;
      if (dut_vec() !== model_vec() || imem_addr !== frozen_pc || !halted) begin
        errors++;
        $display("[TB] FAIL halt_frozen[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    imem[int'(frozen_pc) - 1] = 16'h2000 + 16'(frozen_pc - 8'd1);
    tick(1, 1, 1, 8'h55);
    checks++;
    if (dut_vec() !== {8'h00, 16'hF000, 4'hF, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL reset_in_halt: got %h", dut_vec());
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 1, 8'hFE);
    tick(0, 0, 0, 8'h00);
    checks++;
    if (imem_addr !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL wrap_pre: addr=%h want ff", imem_addr);
    end
    tick(0, 0, 0, 8'h00);
    checks++;
    if (imem_addr !== 8'h00 || instr !== 16'h20FF || pc_plus1 !== 8'h00 || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL wrap: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    logic r, s, d;
    for (int i = 0; i < 256; i++) begin
      imem[i] = ($urandom_range(0, 7) == 0) ? 16'h7000 | 16'($urandom_range(0, 4095)) : 16'($urandom);
    end
    tick(1, 0, 0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      r = m_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 7) == 0);
      tick(r, s, d, 8'($urandom));
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stop_vs_redirect();
    test_stop();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
